framebuffer_arbiter: RTL
========================

FRAMEBUFFER_ARBITER -- requirements
Module: framebuffer_arbiter

Interface
REQ-001 Parameter: ADDR_W, default 17, framebuffer word address width (320x240 = 76800 words).
REQ-002 Parameter: DATA_W, default 8, pixel word width (RRRGGGBB).
REQ-003 Port: i_clk_50mhz  in  1  sole clock, all state on rising edge.
REQ-004 Port: i_reset  in  1  asynchronous, active-high reset.
REQ-005 Port: i_pix_strobe  in  1  one-cycle pulse, every 2nd clock, marking each 25 MHz pixel.
REQ-006 Port: i_x_pixel, i_y_pixel  in  10 each  current scan position.
REQ-007 Port: i_drawing  in  1  scan is inside visible 640x480 area.
REQ-008 Port: o_pixel  out  DATA_W  registered pixel colour to DAC.
REQ-009 Port: i_wr_valid  in  2  write request, port 0 and port 1.
REQ-010 Port: i_wr_addr0, i_wr_addr1  in  ADDR_W each  write word address.
REQ-011 Port: i_wr_data0, i_wr_data1  in  DATA_W each  write data.
REQ-012 Port: o_wr_ready  out  2  write accepted this cycle when valid and ready both high.
REQ-013 Port: i_clear_start  in  1  one-cycle pulse requesting full-screen fill.
REQ-014 Port: i_clear_colour  in  DATA_W  fill value, sampled with i_clear_start.
REQ-015 Port: o_clear_busy  out  1  fill in progress.
REQ-016 Port: o_mem_en, o_mem_we  out  1 each  registered SRAM enable and write enable.
REQ-017 Port: o_mem_addr  out  ADDR_W; o_mem_wdata  out  DATA_W; both registered.
REQ-018 Port: i_mem_rdata  in  DATA_W  synchronous SRAM read data, valid one cycle after o_mem_en with o_mem_we low.

Function
REQ-019 Video address SHALL be (y>>1)*320 + (x>>1), computed at full ADDR_W width without truncation.
REQ-020 Video cycle: a cycle T with i_pix_strobe=1 and i_drawing=1 SHALL drive o_mem_en=1, o_mem_we=0 with the video address during cycle T+1.
REQ-021 o_pixel SHALL take i_mem_rdata at the edge ending cycle T+2 (update visible from T+3).
REQ-022 For a strobe with i_drawing=0, or x>=640, or y>=480: no memory read; o_pixel SHALL become 0 at the same T+3 point.
REQ-023 Free cycle: any cycle C without (i_pix_strobe and i_drawing); only free cycles SHALL grant writers or fill, bus driven in C+1.
REQ-024 Video SHALL always win over writers and fill; o_wr_ready SHALL be 0 in non-free cycles.
REQ-025 Writers: in a free cycle with o_clear_busy=0, at most one o_wr_ready bit SHALL be high, chosen round-robin among valid ports, priority pointer moving past the granted port after each transfer.
REQ-026 o_wr_ready SHALL be 0 for a port whose i_wr_valid is 0; ready is combinational from valid, slot and pointer.
REQ-027 Accepted write with address >= 76800 SHALL complete the handshake but drive o_mem_en=0 in C+1 (dropped).
REQ-028 Bus idle cycles SHALL drive o_mem_en=0, o_mem_we=0; o_mem_addr/o_mem_wdata hold prior values.
REQ-029 Fill FSM states: IDLE, CLEAR. IDLE->CLEAR on i_clear_start; colour latched, counter=0.
REQ-030 In CLEAR, each free cycle SHALL write colour to counter address then increment; after writing 76799 -> IDLE.
REQ-031 o_clear_busy SHALL be 1 exactly while in CLEAR; all o_wr_ready SHALL be 0 while busy.
REQ-032 i_clear_start while in CLEAR SHALL be ignored (no restart, colour unchanged).

Reset
REQ-033 Asserting i_reset SHALL immediately force: o_pixel=0, o_mem_en=0, o_mem_we=0, o_mem_addr=0, o_mem_wdata=0, o_wr_ready=0, o_clear_busy=0, FSM=IDLE, counter=0, round-robin pointer favouring port 0.
REQ-034 Reset during CLEAR SHALL abort the fill; no further fill writes after deassertion.

Verification
REQ-035 Strobe, drawing=1, x=3, y=5 -> o_mem_addr=641, en=1, we=0 in T+1; rdata 0xA5 in T+2 -> o_pixel=0xA5 from T+3.
REQ-036 Both ports valid continuously during blanking -> grants alternate 0,1,0,1; one write per cycle, addresses/data match ports.
REQ-037 Port 0 valid in cycle with strobe and drawing=1 -> o_wr_ready=0; granted next free cycle; video read not delayed.
REQ-038 i_clear_start, colour 0x1C, drawing=0 -> 76800 writes, addresses 0..76799 each once, o_clear_busy high 76800 cycles, writers stalled.
REQ-039 Write to address 80000 -> handshake completes, o_mem_en=0 next cycle; reset asserted mid-clear at counter 1000 -> outputs 0 at once, no writes after release.

Source files
------------

// File: rtl/framebuffer_arbiter.sv
// Single-port framebuffer SRAM arbiter: video scan-out reads always win, free
// cycles go to the full-screen fill engine or to two round-robin write ports.
module framebuffer_arbiter #(
  parameter int ADDR_W = 17,
  parameter int DATA_W = 8
) (
  input  logic              i_clk_50mhz,
  input  logic              i_reset,
  input  logic              i_pix_strobe,
  input  logic [9:0]        i_x_pixel,
  input  logic [9:0]        i_y_pixel,
  input  logic              i_drawing,
  output logic [DATA_W-1:0] o_pixel,
  input  logic [1:0]        i_wr_valid,
  input  logic [ADDR_W-1:0] i_wr_addr0,
  input  logic [ADDR_W-1:0] i_wr_addr1,
  input  logic [DATA_W-1:0] i_wr_data0,
  input  logic [DATA_W-1:0] i_wr_data1,
  output logic [1:0]        o_wr_ready,
  input  logic              i_clear_start,
  input  logic [DATA_W-1:0] i_clear_colour,
  output logic              o_clear_busy,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(76800);
  localparam logic [ADDR_W-1:0] FB_LAST  = ADDR_W'(76799);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] cnt, cnt_nxt;
  logic [DATA_W-1:0] colour, colour_nxt;
  logic              ptr;
  logic              vid, rd, free, fill_go;
  logic [ADDR_W-1:0] vaddr, waddr;
  logic [DATA_W-1:0] wdata;
  logic [1:0]        ready;
  logic [2:1]        stb_pipe, rd_pipe;
  logic              en_nxt, we_nxt;
  logic [ADDR_W-1:0] addr_nxt;
  logic [DATA_W-1:0] wdata_nxt;

  // A strobe inside the drawing window owns the slot even when off-screen.
  assign vid     = i_pix_strobe & i_drawing;
  assign free    = ~vid;
  assign rd      = vid & (i_x_pixel < 10'd640) & (i_y_pixel < 10'd480);
  assign vaddr   = ADDR_W'(i_y_pixel[9:1]) * ADDR_W'(320) + ADDR_W'(i_x_pixel[9:1]);
  assign fill_go = (state == CLEAR) & free;

  assign o_clear_busy = (state == CLEAR);

  always_comb begin
    ready = 2'b00;
    if (free && state == IDLE && !i_reset) begin
      ready[0] = i_wr_valid[0] & (~ptr | ~i_wr_valid[1]);
      ready[1] = i_wr_valid[1] & ( ptr | ~i_wr_valid[0]);
    end
  end
  assign o_wr_ready = ready;
  assign waddr = ready[1] ? i_wr_addr1 : i_wr_addr0;
  assign wdata = ready[1] ? i_wr_data1 : i_wr_data0;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    colour_nxt = colour;
    case (state)
      IDLE: if (i_clear_start) begin
        state_nxt  = CLEAR;
        cnt_nxt    = '0;
        colour_nxt = i_clear_colour;
      end
      CLEAR: if (free) begin
        if (cnt == FB_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    en_nxt    = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = o_mem_addr;
    wdata_nxt = o_mem_wdata;
    if (rd) begin
      en_nxt   = 1'b1;
      addr_nxt = vaddr;
    end else if (fill_go) begin
      en_nxt    = 1'b1;
      we_nxt    = 1'b1;
      addr_nxt  = cnt;
      wdata_nxt = colour;
    end else if (|ready && waddr < FB_WORDS) begin
      en_nxt    = 1'b1;
      we_nxt    = 1'b1;
      addr_nxt  = waddr;
      wdata_nxt = wdata;
    end
  end

  always_ff @(posedge i_clk_50mhz or posedge i_reset) begin
    if (i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      colour      <= '0;
      ptr         <= 1'b0;
      stb_pipe    <= '0;
      rd_pipe     <= '0;
      o_pixel     <= '0;
      o_mem_en    <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      colour      <= colour_nxt;
      if (ready[0])      ptr <= 1'b1;
      else if (ready[1]) ptr <= 1'b0;
      stb_pipe    <= {stb_pipe[1], i_pix_strobe};
      rd_pipe     <= {rd_pipe[1], rd};
      // Read data lands two cycles after the strobe; blank strobes output black.
      if (stb_pipe[2]) o_pixel <= rd_pipe[2] ? i_mem_rdata : '0;
      o_mem_en    <= en_nxt;
      o_mem_we    <= we_nxt;
      o_mem_addr  <= addr_nxt;
      o_mem_wdata <= wdata_nxt;
    end
  end
endmodule
